forwarding_hazard_unit: RTL and testbench

- Produces the operand-forwarding mux selects (rs1mux, rs2mux, wdatamux encodings) and the load-use stall for the 5-stage RV32I pipeline.
- Keeps its own shadow pipeline of register-usage metadata (EX, MEM, WB) fed from decode.
- Sits beside the datapath. Consumes ID-stage decode fields and the global stall/flush, and drives the select lines the datapath muxes decode.

---
 rtl/forwarding_hazard_unit_if.sv | 33 +++
 rtl/forwarding_hazard_unit.sv | 128 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forwarding_hazard_unit_if.sv
// Decode/control signals into the forwarding and hazard unit, and the mux selects
// and stall request it hands back to the datapath.
interface forwarding_hazard_unit_if #(
    parameter int REG_IDX_W = 5
);
    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 id_is_store;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_reg_write;
    logic                 id_is_load;
    logic                 stall_in;
    logic                 flush;
    logic [1:0]           rs1mux_sel;
    logic [1:0]           rs2mux_sel;
    logic                 wdatamux_sel;
    logic                 load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_store,
               id_rd, id_reg_write, id_is_load, stall_in, flush,
        input  rs1mux_sel, rs2mux_sel, wdatamux_sel, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_store,
               id_rd, id_reg_write, id_is_load, stall_in, flush,
        output rs1mux_sel, rs2mux_sel, wdatamux_sel, load_use_stall
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selects and load-use stall for the 5-stage RV32I pipeline,
// driven from a shadow pipe of register-usage metadata (EX, MEM, WB).
module forwarding_hazard_unit #(
    parameter int REG_IDX_W      = 5,
    parameter bit LOAD_STORE_FWD = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    forwarding_hazard_unit_if.slave hz
);

    logic                 ex_v, ex_u1, ex_u2, ex_st, ex_rw, ex_ld;
    logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;

    logic                 mem_v, mem_rw, mem_ld, mem_st;
    logic [REG_IDX_W-1:0] mem_rd, mem_rs2;

    logic                 wb_v, wb_rw;
    logic [REG_IDX_W-1:0] wb_rd;

    logic                 hit1, hit2, lu_stall;
    logic [1:0]           rs1_sel, rs2_sel;
    logic                 wdata_sel;

    // A stage produces r only if it is live, writes, and targets a non-zero register.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [REG_IDX_W-1:0] rd,
                                    input logic [REG_IDX_W-1:0] r);
        return v & rw & (rd != '0) & (rd == r);
    endfunction

    always_comb begin
        hit1     = hz.id_uses_rs1 & (hz.id_rs1 == ex_rd);
        hit2     = (hz.id_uses_rs2 | (hz.id_is_store & ~LOAD_STORE_FWD))
                   & (hz.id_rs2 == ex_rd);
        lu_stall = hz.id_valid & ex_v & ex_ld & (ex_rd != '0) & (hit1 | hit2)
                   & ~hz.flush & ~hz.stall_in;
    end

    // A load sitting in MEM is never a forwarding source; the stall keeps it out of reach.
    always_comb begin
        rs1_sel = 2'b00;
        if (ex_u1) begin
            if (writes(mem_v, mem_rw, mem_rd, ex_rs1) && !mem_ld) begin
                rs1_sel = 2'b01;
            end else if (writes(wb_v, wb_rw, wb_rd, ex_rs1)) begin
                rs1_sel = 2'b10;
            end
        end
    end

    always_comb begin
        rs2_sel = 2'b00;
        if (ex_u2 | ex_st) begin
            if (writes(mem_v, mem_rw, mem_rd, ex_rs2) && !mem_ld) begin
                rs2_sel = 2'b01;
            end else if (writes(wb_v, wb_rw, wb_rd, ex_rs2)) begin
                rs2_sel = 2'b10;
            end
        end
    end

    always_comb begin
        wdata_sel = LOAD_STORE_FWD & mem_v & mem_st & writes(wb_v, wb_rw, wb_rd, mem_rs2);
    end

    assign hz.rs1mux_sel     = rs1_sel;
    assign hz.rs2mux_sel     = rs2_sel;
    assign hz.wdatamux_sel   = wdata_sel;
    assign hz.load_use_stall = lu_stall;

    // A global freeze holds everything; flush and load-use both put a bubble into EX,
    // and a flush also kills the instruction moving from EX into MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v    <= 1'b0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_u1   <= 1'b0;
            ex_u2   <= 1'b0;
            ex_st   <= 1'b0;
            ex_rd   <= '0;
            ex_rw   <= 1'b0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_rd  <= '0;
            mem_rw  <= 1'b0;
            mem_ld  <= 1'b0;
            mem_st  <= 1'b0;
            mem_rs2 <= '0;
            wb_v    <= 1'b0;
            wb_rd   <= '0;
            wb_rw   <= 1'b0;
        end else if (!hz.stall_in) begin
            wb_v    <= mem_v;
            wb_rd   <= mem_rd;
            wb_rw   <= mem_rw;
            mem_v   <= ex_v & ~hz.flush;
            mem_rd  <= ex_rd;
            mem_rw  <= ex_rw;
            mem_ld  <= ex_ld;
            mem_st  <= ex_st;
            mem_rs2 <= ex_rs2;
            if (hz.flush || lu_stall) begin
                ex_v   <= 1'b0;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
                ex_u1  <= 1'b0;
                ex_u2  <= 1'b0;
                ex_st  <= 1'b0;
                ex_rd  <= '0;
                ex_rw  <= 1'b0;
                ex_ld  <= 1'b0;
            end else begin
                ex_v   <= hz.id_valid;
                ex_rs1 <= hz.id_rs1;
                ex_rs2 <= hz.id_rs2;
                ex_u1  <= hz.id_uses_rs1;
                ex_u2  <= hz.id_uses_rs2;
                ex_st  <= hz.id_is_store;
                ex_rd  <= hz.id_rd;
                ex_rw  <= hz.id_reg_write;
                ex_ld  <= hz.id_is_load;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: two units (store forwarding on and off) see the same decode
// stream; expected {rs1,rs2,wdata,stall} per cycle are queued and checked mid-cycle.
module tb_forwarding_hazard_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       st;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       sin;
        logic       fl;
        logic [5:0] ea;
        logic [5:0] eb;
    } step_t;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    localparam logic [5:0] E0 = 6'b00_00_0_0;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    forwarding_hazard_unit_if #(.REG_IDX_W(5)) fa ();
    forwarding_hazard_unit_if #(.REG_IDX_W(5)) fb ();

    forwarding_hazard_unit #(.REG_IDX_W(5), .LOAD_STORE_FWD(1'b1)) dut_a (
        .clk(clk),
        .rst(rst),
        .hz (fa)
    );

    forwarding_hazard_unit #(.REG_IDX_W(5), .LOAD_STORE_FWD(1'b0)) dut_b (
        .clk(clk),
        .rst(rst),
        .hz (fb)
    );

    assign fb.id_valid     = fa.id_valid;
    assign fb.id_rs1       = fa.id_rs1;
    assign fb.id_rs2       = fa.id_rs2;
    assign fb.id_uses_rs1  = fa.id_uses_rs1;
    assign fb.id_uses_rs2  = fa.id_uses_rs2;
    assign fb.id_is_store  = fa.id_is_store;
    assign fb.id_rd        = fa.id_rd;
    assign fb.id_reg_write = fa.id_reg_write;
    assign fb.id_is_load   = fa.id_is_load;
    assign fb.stall_in     = fa.stall_in;
    assign fb.flush        = fa.flush;

    wire [11:0] obs = {fa.rs1mux_sel, fa.rs2mux_sel, fa.wdatamux_sel, fa.load_use_stall,
                       fb.rs1mux_sel, fb.rs2mux_sel, fb.wdatamux_sel, fb.load_use_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t nop_i();
        instr_t r;
        r = '0;
        return r;
    endfunction

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t r;
        r     = '0;
        r.v   = 1'b1;
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.u1  = 1'b1;
        r.u2  = 1'b1;
        r.rd  = 5'(rd);
        r.rw  = 1'b1;
        return r;
    endfunction

    function automatic instr_t alui(input int rd, input int rs1);
        instr_t r;
        r     = '0;
        r.v   = 1'b1;
        r.rs1 = 5'(rs1);
        r.u1  = 1'b1;
        r.rd  = 5'(rd);
        r.rw  = 1'b1;
        return r;
    endfunction

    function automatic instr_t load(input int rd, input int rs1);
        instr_t r;
        r     = alui(rd, rs1);
        r.ld  = 1'b1;
        return r;
    endfunction

    function automatic instr_t store(input int rs1, input int rs2);
        instr_t r;
        r     = '0;
        r.v   = 1'b1;
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.u1  = 1'b1;
        r.st  = 1'b1;
        return r;
    endfunction

    function automatic step_t mk(input instr_t ins, input logic sin, input logic fl,
                                 input logic [5:0] ea, input logic [5:0] eb);
        step_t s;
        s.ins = ins;
        s.sin = sin;
        s.fl  = fl;
        s.ea  = ea;
        s.eb  = eb;
        return s;
    endfunction

    task automatic drive(input instr_t ins, input logic sin, input logic fl);
        fa.id_valid     = ins.v;
        fa.id_rs1       = ins.rs1;
        fa.id_rs2       = ins.rs2;
        fa.id_uses_rs1  = ins.u1;
        fa.id_uses_rs2  = ins.u2;
        fa.id_is_store  = ins.st;
        fa.id_rd        = ins.rd;
        fa.id_reg_write = ins.rw;
        fa.id_is_load   = ins.ld;
        fa.stall_in     = sin;
        fa.flush        = fl;
    endtask

    task automatic idle(input int n);
        drive(nop_i(), 1'b0, 1'b0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        drive(alu(5, 1, 2), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        sb_q.push_back('{E0, E0});
        e = sb_q.pop_front();
        checks++;
        if (obs !== {e.a, e.b}) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b exp=%b", obs, {e.a, e.b});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 1), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(7, 6, 5), 1'b0, 1'b0, 6'b01_00_0_0, 6'b01_00_0_0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, 6'b01_10_0_0, 6'b01_10_0_0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_forward();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(alu(5, 1, 2),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),       1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(7, 1, 5),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),       1'b0, 1'b0, 6'b00_10_0_0, 6'b00_10_0_0));
        s.push_back(mk(alu(5, 1, 2),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(5, 3, 4),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(8, 5, 5),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),       1'b0, 1'b0, 6'b01_01_0_0, 6'b01_01_0_0));
        s.push_back(mk(alui(0, 1),    1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(9, 0, 0),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(10, 0, 0), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),       1'b0, 1'b0, E0, E0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL forward[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(load(5, 1),   1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, 6'b00_00_0_1, 6'b00_00_0_1));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, 6'b10_00_0_0, 6'b10_00_0_0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, E0, E0));
        s.push_back(mk(load(7, 1),   1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(8, 2, 7), 1'b0, 1'b0, 6'b00_00_0_1, 6'b00_00_0_1));
        s.push_back(mk(alu(8, 2, 7), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, 6'b00_10_0_0, 6'b00_10_0_0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL load_use[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    // The store is held in ID for two cycles because the no-forwarding unit stalls it.
    task automatic test_store();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(load(5, 1),  1'b0, 1'b0, E0, E0));
        s.push_back(mk(store(3, 5), 1'b0, 1'b0, E0, 6'b00_00_0_1));
        s.push_back(mk(store(3, 5), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),     1'b0, 1'b0, 6'b00_10_1_0, 6'b00_10_0_0));
        s.push_back(mk(nop_i(),     1'b0, 1'b0, E0, E0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL store_fwd[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall_in();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 1), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b1, 1'b0, 6'b01_00_0_0, 6'b01_00_0_0));
        s.push_back(mk(nop_i(),      1'b1, 1'b1, 6'b01_00_0_0, 6'b01_00_0_0));
        s.push_back(mk(nop_i(),      1'b1, 1'b0, 6'b01_00_0_0, 6'b01_00_0_0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, 6'b01_00_0_0, 6'b01_00_0_0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, E0, E0));
        s.push_back(mk(load(5, 1),   1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 2), 1'b1, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, 6'b00_00_0_1, 6'b00_00_0_1));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, 6'b10_00_0_0, 6'b10_00_0_0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL stall_in[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        step_t s[$];
        exp_t  e;
        idle(3);
        s.push_back(mk(load(5, 1),   1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 2), 1'b0, 1'b1, E0, E0));
        s.push_back(mk(alu(7, 5, 5), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(5, 1, 2), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(alu(6, 5, 5), 1'b0, 1'b1, E0, E0));
        s.push_back(mk(alu(8, 5, 5), 1'b0, 1'b0, E0, E0));
        s.push_back(mk(nop_i(),      1'b0, 1'b0, E0, E0));
        foreach (s[i]) begin
            drive(s[i].ins, s[i].sin, s[i].fl);
            sb_q.push_back('{s[i].ea, s[i].eb});
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (obs !== {e.a, e.b}) begin
                failures++;
                $display("[TB] FAIL flush[%0d] got=%b exp=%b", i, obs, {e.a, e.b});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        idle(3);
        drive(alu(5, 1, 2), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(alu(6, 5, 1), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(nop_i(), 1'b0, 1'b0);
        sb_q.push_back('{6'b01_00_0_0, 6'b01_00_0_0});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (obs !== {e.a, e.b}) begin
            failures++;
            $display("[TB] FAIL reset_mid_before got=%b exp=%b", obs, {e.a, e.b});
        end
        #2;
        rst = 1'b0;
        sb_q.push_back('{E0, E0});
        #1;
        e = sb_q.pop_front();
        checks++;
        if (obs !== {e.a, e.b}) begin
            failures++;
            $display("[TB] FAIL reset_mid_async got=%b exp=%b", obs, {e.a, e.b});
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(alu(7, 5, 6), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(nop_i(), 1'b0, 1'b0);
        sb_q.push_back('{E0, E0});
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (obs !== {e.a, e.b}) begin
            failures++;
            $display("[TB] FAIL reset_mid_after got=%b exp=%b", obs, {e.a, e.b});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(nop_i(), 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_forward();
        test_load_use();
        test_store();
        test_stall_in();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
